gmul_iterative: RTL and testbench
=================================

Name: gmul_iterative

Overview:
Sequential, handshaked Galois-field multiplier computing p = a·b mod (x^DWIDTH + m) over GF(2^DWIDTH).
- BPC bits of multiplier b are consumed per cycle, LSB first; the cycle count is skipped once the remaining b bits are all zero.
- Serves crypto/CRC pipeline stages that need wide fields (GF(2^8)…GF(2^128)) without a fully unrolled combinational array.
- Valid/ready on both sides; one operation in flight.

Parameters:
DWIDTH, 8, field width: width of a, m, p (≥2)
BWIDTH, 8, width of multiplier b (≥1)
BPC, 1, b bits processed per cycle; must divide BWIDTH (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  synchronous abort: return to IDLE, drop any result
in_valid  in  1  operand valid
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  DWIDTH  multiplicand (field element)
b  in  BWIDTH  multiplier (polynomial coefficients, bit i = x^i)
m  in  DWIDTH  reduction polynomial without implicit x^DWIDTH term (AES: 0x1B)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
p  out  DWIDTH  product
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1, out_valid=0, busy=0, p=0; internal a_cur/b_sh/m_r/cnt cleared. The same applies when reset asserts mid-operation; the operation is lost.
- State: IDLE.
  - in_ready=1.
  - Accept when in_valid&&in_ready at edge T: a_cur←a, b_sh←b, m_r←m, p_acc←0, go RUN.
  - Inputs are sampled only at accept and are don't-care afterwards.
- State: RUN, one step per cycle.
  - For j=0..BPC-1: if b_sh[j], p_acc ^= a_cur_j; a_cur_(j+1) = mul2(a_cur_j, m_r).
  - mul2(x) = {x[DWIDTH-2:0],0} ^ (m_r & {DWIDTH{x[DWIDTH-1]}}).
  - Then b_sh >>= BPC.
  - Go DONE when the shifted b_sh==0. The step count is always ≥1, even if b==0.
  - Steps k = max(1, ceil((msb_index(b)+1)/BPC)), bounded by BWIDTH/BPC.
- State: DONE.
  - p=p_acc (registered), out_valid=1, held stable while out_ready=0.
  - On out_valid&&out_ready: go IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - No same-cycle accept of new operands.
- Latency: accept edge T → out_valid high after edge T+k. Minimum issue interval is k+2 cycles.
- clr=1 at an edge: state→IDLE, out_valid=0, p retains its last value. clr takes priority over accept and over result handoff.
- p holds its last delivered value in IDLE/RUN and is only updated on entry to DONE.
- Arithmetic is pure XOR/AND, no carries. Bits of b at index ≥ DWIDTH are legal: they keep reducing mod m.
- No X propagation from a/b/m when not accepting. Outputs never X after reset.

Test Plan:
1. DWIDTH=8, BPC=1, a=0x57, b=0x83, m=0x1B, out_ready=1 → p=0xC1. out_valid rises after edge T+8, high exactly 1 cycle. in_ready low from T+1 until the cycle after handoff.
2. Same config, a=0x57, b=0x13 → p=0xFE after edge T+5 (early termination). Then b=0x00, a=0xFF → p=0x00 after edge T+1.
3. BPC=4, a=0x57, b=0x83, m=0x1B → p=0xC1 after edge T+2. BPC=8 → after edge T+1.
4. Backpressure: test 1 with out_ready=0 for 3 cycles after out_valid → p=0xC1 and out_valid stable, in_ready=0, busy=1. The new in_valid is ignored until the handoff cycle completes.
5. clr asserted 3 cycles into test 1 → next cycle IDLE, in_ready=1, out_valid never rises. A following a=0x02, b=0x80, m=0x1B gives p=mul2^7(0x02)=0x1B.
6. rst pulse mid-RUN, asynchronous and not clock-aligned → outputs go immediately to reset values (p=0, out_valid=0, busy=0). After release, test 2 passes unchanged. DWIDTH=16, BWIDTH=16, BPC=2, a=0x8000, b=0x0002, m=0x002B → p=0x002B.

Source files
------------

// File: rtl/gmul_iterative.sv
// Iterative GF(2^DWIDTH) multiplier: p = a * b mod (x^DWIDTH + m).
// Consumes BPC bits of b per cycle, LSB first, and stops as soon as the
// remaining multiplier bits are all zero. One operation in flight, with
// valid/ready handshakes on both the operand and the result side.
module gmul_iterative #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned BWIDTH = 8,
    parameter int unsigned BPC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] a,
    input  logic [BWIDTH-1:0] b,
    input  logic [DWIDTH-1:0] m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] p,
    output logic              busy
);

    // Reject configurations the datapath cannot support
    if (DWIDTH < 2) begin : g_bad_dwidth
        $error("gmul_iterative: DWIDTH must be at least 2");
    end
    if (BWIDTH < 1) begin : g_bad_bwidth
        $error("gmul_iterative: BWIDTH must be at least 1");
    end
    if (BPC < 1) begin : g_bad_bpc
        $error("gmul_iterative: BPC must be at least 1");
    end else if ((BWIDTH % BPC) != 0) begin : g_bad_bpc_div
        $error("gmul_iterative: BPC must divide BWIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state;
    logic [DWIDTH-1:0] a_cur;   // a * x^(bits consumed so far), already reduced
    logic [BWIDTH-1:0] b_sh;    // multiplier bits still to be consumed
    logic [DWIDTH-1:0] m_r;     // reduction polynomial latched at accept
    logic [DWIDTH-1:0] p_acc;   // running partial product

    logic [DWIDTH-1:0] a_step;
    logic [DWIDTH-1:0] p_step;
    logic [BWIDTH-1:0] b_step;

    // Multiply by x and fold the overflow term back in through m
    function automatic logic [DWIDTH-1:0] mul2(input logic [DWIDTH-1:0] x,
                                               input logic [DWIDTH-1:0] poly);
        mul2 = {x[DWIDTH-2:0], 1'b0} ^ (poly & {DWIDTH{x[DWIDTH-1]}});
    endfunction

    // One RUN step: fold in BPC multiplier bits, advancing a_cur by x each bit
    always_comb begin
        a_step = a_cur;
        p_step = p_acc;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (b_sh[j]) begin
                p_step = p_step ^ a_step;
            end
            a_step = mul2(a_step, m_r);
        end
        b_step = b_sh >> BPC;
    end

    // Control FSM with registered handshake outputs and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            a_cur     <= '0;
            b_sh      <= '0;
            m_r       <= '0;
            p_acc     <= '0;
            p         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            // Abort wins over accept and handoff; p keeps its last value
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_cur    <= a;
                        b_sh     <= b;
                        m_r      <= m;
                        p_acc    <= '0;
                        state    <= StRun;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StRun: begin
                    a_cur <= a_step;
                    p_acc <= p_step;
                    b_sh  <= b_step;
                    // Always at least one step, even when b is zero
                    if (b_step == '0) begin
                        p         <= p_step;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmul_iterative.sv
// Scoreboard bench for gmul_iterative: four instances cover BPC=1/4/8 at
// GF(2^8) and BPC=2 at GF(2^16). Stimulus pushes expected results; a
// negedge monitor checks latency on out_valid rise and the product on handoff.
module tb_gmul_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [15:0] m16 = '0;
    logic        iv [4];
    logic        ir [4];
    logic        ov [4];
    logic        bz [4];
    logic [15:0] pv [4];
    logic [7:0]  p0, p1, p2;
    logic [15:0] p3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          id;
        logic [15:0] p;
        int          k;
        int          t;
    } exp_t;
    exp_t sb[$];
    logic prev_ov [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gmul_iterative #(.DWIDTH(8), .BWIDTH(8), .BPC(1)) u_b1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a16[7:0]), .b(b16[7:0]), .m(m16[7:0]), .out_valid(ov[0]),
        .out_ready(out_ready), .p(p0), .busy(bz[0]));
    gmul_iterative #(.DWIDTH(8), .BWIDTH(8), .BPC(4)) u_b4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a16[7:0]), .b(b16[7:0]), .m(m16[7:0]), .out_valid(ov[1]),
        .out_ready(out_ready), .p(p1), .busy(bz[1]));
    gmul_iterative #(.DWIDTH(8), .BWIDTH(8), .BPC(8)) u_b8 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a16[7:0]), .b(b16[7:0]), .m(m16[7:0]), .out_valid(ov[2]),
        .out_ready(out_ready), .p(p2), .busy(bz[2]));
    gmul_iterative #(.DWIDTH(16), .BWIDTH(16), .BPC(2)) u_w16 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a16), .b(b16), .m(m16), .out_valid(ov[3]),
        .out_ready(out_ready), .p(p3), .busy(bz[3]));

    assign pv[0] = {8'h00, p0};
    assign pv[1] = {8'h00, p1};
    assign pv[2] = {8'h00, p2};
    assign pv[3] = p3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present operands for one accept edge, then poison them
    task automatic issue(input int id, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] im, input logic [15:0] ep, input int k,
                         input bit push);
        int n = 0;
        while (!ir[id] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[id]) chk("in_ready_timeout", 32'd0, 32'd1);
        a16 = ia;
        b16 = ib;
        m16 = im;
        iv[id] = 1'b1;
        @(posedge clk); #1;
        iv[id] = 1'b0;
        a16 = 'x;
        b16 = 'x;
        m16 = 'x;
        if (push) sb.push_back('{id, ep, k, cyc});
    endtask

    task automatic wait_drain(input int id);
        int n = 0;
        while ((sb.size() != 0 || !ir[id]) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input int id, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] im, input logic [15:0] ep, input int k);
        issue(id, ia, ib, im, ep, k, 1'b1);
        wait_drain(id);
    endtask

    // Monitor: latency on out_valid rise, product and ordering on handoff
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ov[i] === 1'b1 && prev_ov[i] !== 1'b1) begin
                if (sb.size() == 0 || sb[0].id != i) chk("spurious_valid", 32'd1, 32'd0);
                else chk("latency", cyc - sb[0].t, sb[0].k);
            end
            if (ov[i] === 1'b1 && out_ready && sb.size() != 0 && sb[0].id == i) begin
                chk("product", {16'h0, pv[i]}, {16'h0, sb[0].p});
                void'(sb.pop_front());
            end
            prev_ov[i] = ov[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            prev_ov[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", {31'd0, ir[i]}, 32'd1);
            chk("rst_out_valid", {31'd0, ov[i]}, 32'd0);
            chk("rst_busy", {31'd0, bz[i]}, 32'd0);
            chk("rst_p", {16'h0, pv[i]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: FIPS-197 example, full 8 steps, single-cycle out_valid
        issue(0, 16'h57, 16'h83, 16'h1B, 16'hC1, 8, 1'b1);
        chk("t1_in_ready_low", {31'd0, ir[0]}, 32'd0);
        chk("t1_busy_high", {31'd0, bz[0]}, 32'd1);
        n = 0;
        while (ov[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t1_valid_seen", {31'd0, ov[0]}, 32'd1);
        @(posedge clk); #1;
        chk("t1_valid_one_cycle", {31'd0, ov[0]}, 32'd0);
        chk("t1_in_ready_back", {31'd0, ir[0]}, 32'd1);
        wait_drain(0);

        // Test 2: early termination and zero multiplier
        run(0, 16'h57, 16'h13, 16'h1B, 16'hFE, 5);
        run(0, 16'hFF, 16'h00, 16'h1B, 16'h00, 1);

        // Test 3: wider steps per cycle
        run(1, 16'h57, 16'h83, 16'h1B, 16'hC1, 2);
        run(1, 16'h57, 16'h13, 16'h1B, 16'hFE, 2);
        run(1, 16'hFF, 16'h00, 16'h1B, 16'h00, 1);
        run(2, 16'h57, 16'h83, 16'h1B, 16'hC1, 1);
        run(2, 16'h57, 16'h13, 16'h1B, 16'hFE, 1);

        // Test 4: backpressure holds the result; new operands ignored meanwhile
        out_ready = 1'b0;
        issue(0, 16'h57, 16'h83, 16'h1B, 16'hC1, 8, 1'b1);
        n = 0;
        while (ov[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a16 = 16'h01;
        b16 = 16'h01;
        m16 = 16'h1B;
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, ov[0]}, 32'd1);
            chk("t4_hold_p", {16'h0, pv[0]}, 32'hC1);
            chk("t4_hold_in_ready", {31'd0, ir[0]}, 32'd0);
            chk("t4_hold_busy", {31'd0, bz[0]}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("t4_after_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("t4_after_busy", {31'd0, bz[0]}, 32'd0);
        chk("t4_after_valid", {31'd0, ov[0]}, 32'd0);
        wait_drain(0);

        // Test 5: clr aborts mid-run, result never appears
        issue(0, 16'h57, 16'h83, 16'h1B, 16'h00, 8, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("t5_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("t5_busy", {31'd0, bz[0]}, 32'd0);
        chk("t5_p_retained", {16'h0, pv[0]}, 32'hC1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov[0] === 1'b1) seen = 1'b1;
        end
        chk("t5_no_valid", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        run(0, 16'h02, 16'h80, 16'h1B, 16'h1B, 8);

        // Test 6: asynchronous reset mid-run, off the clock edge
        issue(0, 16'h57, 16'h83, 16'h1B, 16'h00, 8, 1'b0);
        @(posedge clk); #4;
        rst = 1'b1;
        #1;
        chk("t6_rst_p", {16'h0, pv[0]}, 32'd0);
        chk("t6_rst_valid", {31'd0, ov[0]}, 32'd0);
        chk("t6_rst_busy", {31'd0, bz[0]}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, ir[0]}, 32'd1);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run(0, 16'h57, 16'h13, 16'h1B, 16'hFE, 5);
        run(0, 16'hFF, 16'h00, 16'h1B, 16'h00, 1);
        run(3, 16'h8000, 16'h0002, 16'h002B, 16'h002B, 1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
